// File: rtl/tc_pkg.sv
// tc_pkg: shared types and constants for the tc_target transaction endpoint
package tc_pkg;
  localparam int TC_DEPTH = 4;
  localparam int TC_AMAX = 16;
  localparam int TC_DMAX = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} tc_state_t;
  typedef struct packed {
    logic               rnw;
    logic [TC_AMAX-1:0] addr;
    logic [TC_DMAX-1:0] wdata;
  } tc_entry_t;
endpackage

// File: rtl/tc_txn_fifo.sv
// tc_txn_fifo: 4-entry in-order transaction queue with occupancy count
module tc_txn_fifo
  import tc_pkg::*;
(
  input  logic      clk_bus,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  tc_entry_t din,
  output tc_entry_t dout,
  output logic      full,
  output logic      empty,
  output logic [2:0] count
);
  tc_entry_t  mem [TC_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic       do_push, do_pop;
  assign full    = count == 3'(TC_DEPTH);
  assign empty   = count == 3'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  // entry payload needs no reset; only pointers and count define validity
  always_ff @(posedge clk_bus) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointer and occupancy update; simultaneous push and pop keeps count
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, do_push} - {2'b0, do_pop};
    end
  end
endmodule

// File: rtl/tc_target.sv
// tc_target: latency-timed memory target serving queued reads/writes in order
module tc_target
  import tc_pkg::*;
#(
  parameter int TC_AWIDTH = 8,
  parameter int TC_DWIDTH = 8,
  parameter int TC_LAT    = 2
) (
  input  logic                 clk_bus,
  input  logic                 rst_n,
  input  logic                 tc_req,
  input  logic                 tc_rnw,
  input  logic [TC_AWIDTH-1:0] tc_addr,
  input  logic [TC_DWIDTH-1:0] tc_wdata,
  output logic                 tc_aack,
  output logic                 tc_rack,
  output logic [TC_DWIDTH-1:0] tc_rdata,
  output logic                 tc_wack,
  output logic [2:0]           tc_pend_cnt
);
  localparam logic [3:0] LAT_M1 = 4'(TC_LAT - 1);
  localparam tc_state_t LOAD_ST = (TC_LAT == 1) ? RESP : WAIT;
  tc_state_t            state, nxt;
  logic [3:0]           timer, timer_nxt;
  logic [TC_DWIDTH-1:0] mem [2**TC_AWIDTH];
  tc_entry_t            din, head;
  logic                 full, empty, accept, resp;
  logic [2:0]           count;
  logic [TC_AWIDTH-1:0] head_addr;
  logic                 unused_hi;
  assign tc_aack     = !rst_n || !full;
  assign accept      = rst_n && tc_req && tc_aack;
  assign din         = '{rnw: tc_rnw, addr: TC_AMAX'(tc_addr), wdata: TC_DMAX'(tc_wdata)};
  assign head_addr   = head.addr[TC_AWIDTH-1:0];
  assign unused_hi   = ^{head.addr, head.wdata};
  assign resp        = rst_n && state == RESP && !empty;
  assign tc_rack     = resp && head.rnw;
  assign tc_wack     = resp && !head.rnw;
  assign tc_rdata    = tc_rack ? mem[head_addr] : '0;
  assign tc_pend_cnt = count;

  tc_txn_fifo u_fifo (
    .clk_bus (clk_bus),
    .rst_n   (rst_n),
    .push    (accept),
    .pop     (resp),
    .din     (din),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // service state and latency timer register
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= 4'd0;
    end else begin
      state <= nxt;
      timer <= timer_nxt;
    end
  end
  // next service step; a push during RESP counts as a remaining entry
  always_comb begin
    nxt       = state;
    timer_nxt = timer;
    case (state)
      IDLE: if (accept) begin
        nxt       = LOAD_ST;
        timer_nxt = LAT_M1;
      end
      WAIT: if (timer <= 4'd1) nxt = RESP;
            else timer_nxt = timer - 4'd1;
      RESP: if (count > 3'd1 || accept) begin
        nxt       = LOAD_ST;
        timer_nxt = LAT_M1;
      end else nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // storage cleared on reset, written when a write completes
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**TC_AWIDTH; i++) mem[i] <= '0;
    end else if (tc_wack) begin
      mem[head_addr] <= head.wdata[TC_DWIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_tc_target.sv
// tb_tc_target: table-driven check of tc_target at latency 2 plus a latency-8 fill sequence
module tb_tc_target;
  logic       clk_bus = 1'b0;
  logic       rst_n, req, rnw, aack, rack, wack;
  logic [7:0] addr, wdata, rdata;
  logic [2:0] cnt;
  logic       rst8_n, req8, rnw8, aack8, rack8, wack8;
  logic [7:0] addr8, wdata8, rdata8;
  logic [2:0] cnt8;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk_bus = ~clk_bus;

  tc_target #(.TC_AWIDTH(8), .TC_DWIDTH(8), .TC_LAT(2)) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .tc_req(req), .tc_rnw(rnw), .tc_addr(addr),
    .tc_wdata(wdata), .tc_aack(aack), .tc_rack(rack), .tc_rdata(rdata),
    .tc_wack(wack), .tc_pend_cnt(cnt)
  );

  tc_target #(.TC_AWIDTH(8), .TC_DWIDTH(8), .TC_LAT(8)) dut8 (
    .clk_bus(clk_bus), .rst_n(rst8_n), .tc_req(req8), .tc_rnw(rnw8), .tc_addr(addr8),
    .tc_wdata(wdata8), .tc_aack(aack8), .tc_rack(rack8), .tc_rdata(rdata8),
    .tc_wack(wack8), .tc_pend_cnt(cnt8)
  );

  typedef struct {
    logic       rst_n, req, rnw;
    logic [7:0] addr, wdata;
    logic       aack, rack, wack;
    logic [7:0] rdata;
    logic [2:0] cnt;
  } vec_t;

  vec_t tv [42];

  function automatic vec_t mk(input logic r, q, w, input logic [7:0] a, d,
                              input logic ea, er, ew, input logic [7:0] ed, input logic [2:0] ec);
    mk = '{r, q, w, a, d, ea, er, ew, ed, ec};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 0; req = 0; rnw = 0; addr = 0; wdata = 0;
    rst8_n = 0; req8 = 0; rnw8 = 1; addr8 = 0; wdata8 = 0;
    tv[0]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[1]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[2]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[3]  = mk(1, 1, 0, 8'h05, 8'h12, 1, 0, 0, 8'h00, 0);
    tv[4]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[5]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 1);
    tv[6]  = mk(1, 1, 1, 8'h05, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[7]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[8]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h12, 1);
    tv[9]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[10] = mk(1, 1, 0, 8'h20, 8'hA5, 1, 0, 0, 8'h00, 0);
    tv[11] = mk(1, 1, 1, 8'h20, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[12] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 2);
    tv[13] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[14] = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'hA5, 1);
    tv[15] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[16] = mk(1, 1, 0, 8'h07, 8'h33, 1, 0, 0, 8'h00, 0);
    tv[17] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[18] = mk(1, 1, 1, 8'h07, 8'h00, 1, 0, 1, 8'h00, 1);
    tv[19] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[20] = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h33, 1);
    tv[21] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[22] = mk(1, 1, 1, 8'h05, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[23] = mk(1, 1, 1, 8'h20, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[24] = mk(1, 1, 1, 8'h07, 8'h00, 1, 1, 0, 8'h12, 2);
    tv[25] = mk(1, 1, 1, 8'h99, 8'h00, 1, 0, 0, 8'h00, 2);
    tv[26] = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'hA5, 3);
    tv[27] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2);
    tv[28] = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h33, 2);
    tv[29] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[30] = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 1);
    tv[31] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[32] = mk(1, 1, 1, 8'h05, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[33] = mk(1, 1, 1, 8'h07, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[34] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2);
    tv[35] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[36] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[37] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[38] = mk(1, 1, 1, 8'h05, 8'h00, 1, 0, 0, 8'h00, 0);
    tv[39] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1);
    tv[40] = mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 1);
    tv[41] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0);
    repeat (2) @(posedge clk_bus);
    for (int i = 0; i < 42; i++) begin
      #1;
      rst_n = tv[i].rst_n; req = tv[i].req; rnw = tv[i].rnw;
      addr = tv[i].addr; wdata = tv[i].wdata;
      @(negedge clk_bus);
      chk("aack",  i, 32'(aack),  32'(tv[i].aack));
      chk("rack",  i, 32'(rack),  32'(tv[i].rack));
      chk("wack",  i, 32'(wack),  32'(tv[i].wack));
      chk("rdata", i, 32'(rdata), 32'(tv[i].rdata));
      chk("pend",  i, 32'(cnt),   32'(tv[i].cnt));
      @(posedge clk_bus);
    end
    for (int c = 0; c < 35; c++) begin
      #1;
      rst8_n = 1; req8 = c <= 8; addr8 = 8'(c);
      @(negedge clk_bus);
      chk("lat8_aack",  c, 32'(aack8),  32'(!(c >= 4 && c <= 8)));
      chk("lat8_rack",  c, 32'(rack8),  32'(c == 8 || c == 16 || c == 24 || c == 32));
      chk("lat8_wack",  c, 32'(wack8),  32'd0);
      chk("lat8_rdata", c, 32'(rdata8), 32'd0);
      chk("lat8_pend",  c, 32'(cnt8),
          (c <= 3) ? c : (c <= 8) ? 4 : (c <= 16) ? 3 : (c <= 24) ? 2 : (c <= 32) ? 1 : 0);
      @(posedge clk_bus);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tc_target.md
TC_TARGET -- requirements
Module: tc_target

Interface
REQ-001 SHALL have parameter TC_AWIDTH, default 8, address width.
REQ-002 SHALL have parameter TC_DWIDTH, default 8, data width.
REQ-003 SHALL have parameter TC_LAT, default 2, service latency in cycles, legal range 1..15.
REQ-004 SHALL have a single clock domain; reset is synchronous and active-low.
REQ-005 clk_bus  input  1  bus clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 tc_req  input  1  initiator request.
REQ-008 tc_rnw  input  1  1 = read, 0 = write.
REQ-009 tc_addr  input  TC_AWIDTH  transaction address.
REQ-010 tc_wdata  input  TC_DWIDTH  write data.
REQ-011 tc_aack  output  1  address acknowledge; may be asserted speculatively without tc_req.
REQ-012 tc_rack  output  1  read-completion strobe.
REQ-013 tc_rdata  output  TC_DWIDTH  read data, valid only while tc_rack=1.
REQ-014 tc_wack  output  1  write-completion strobe.
REQ-015 tc_pend_cnt  output  3  number of accepted, uncompleted transactions.

Function
REQ-016 SHALL accept a transaction in every cycle where tc_req=1 and tc_aack=1, capturing rnw, addr and wdata into a 4-entry in-order transaction FIFO.
REQ-017 SHALL drive tc_aack = (registered pending count < 4), independent of tc_req; when tc_req=0 no entry is captured.
REQ-018 SHALL hold 2^TC_AWIDTH x TC_DWIDTH storage; write completion updates storage[addr] in the same cycle that tc_wack=1.
REQ-019 SHALL complete entries strictly in acceptance order, one at a time; tc_rack and tc_wack are never high in the same cycle.
REQ-020 SHALL time completion as R(k) = max(A(k), R(k-1)) + TC_LAT, where A is the acceptance cycle and R the completion cycle; a completion is never in its acceptance cycle.
REQ-021 SHALL use service FSM states IDLE (FIFO empty), WAIT (timer counting down) and RESP (one-cycle strobe then pop).
REQ-022 FSM transitions: IDLE->WAIT on an accept; WAIT->RESP when the timer expires; RESP->WAIT if entries remain (timer reloaded to TC_LAT); RESP->IDLE otherwise.
REQ-023 Each tc_rack/tc_wack SHALL be a single-cycle pulse per transaction; tc_rdata = storage[addr] at the head entry and is 0 whenever tc_rack=0.
REQ-024 Read completion SHALL reflect every earlier-accepted write, including a write to the same address completing immediately before it.
REQ-025 Simultaneous accept and completion SHALL leave the pending count unchanged; count never exceeds 4 and never underflows.
REQ-026 tc_rack SHALL assert only while at least one read is pending; tc_wack only while at least one write is pending.

Reset
REQ-027 rst_n=0 at a clock edge SHALL clear the FIFO, the count and the timer, set the FSM to IDLE and zero all storage.
REQ-028 During and after reset: tc_aack=1 (the first cycle after release), tc_rack=0, tc_wack=0, tc_rdata=0, tc_pend_cnt=0.
REQ-029 Reset mid-operation SHALL discard pending transactions without issuing any completion for them.

Structure
REQ-030 Package tc_pkg SHALL hold the FSM state enum, TC_DEPTH=4 and the FIFO entry struct (rnw, addr, wdata).
REQ-031 The FIFO SHALL be a sub-module tc_txn_fifo (push, pop, full, empty, count); the FSM, timer and storage SHALL remain in tc_target.

Verification (TC_LAT=2 unless stated)
REQ-032 Write addr 0x05 data 0x12 accepted cycle 10 -> tc_wack in cycle 12; read 0x05 accepted cycle 13 -> tc_rack in cycle 15 with tc_rdata=0x12.
REQ-033 TC_LAT=8, reads accepted in cycles 0-3 -> tc_aack=0 in cycles 4-8; tc_rack in cycles 8, 16, 24, 32; tc_aack=1 again in cycle 9.
REQ-034 Back-to-back write 0x20/0xA5 then read 0x20 in cycles 0 and 1 -> tc_wack in cycle 2, tc_rack in cycle 4 with tc_rdata=0xA5.
REQ-035 tc_req=0 with the FIFO empty -> tc_aack=1, tc_pend_cnt stays 0, no completion strobes.
REQ-036 Two reads pending, rst_n=0 for one cycle -> no tc_rack afterwards, tc_pend_cnt=0, reading any address returns 0x00.
